dot_mac: RTL and testbench

Parametrised, multi-cycle dot-product engine. It computes the dot product of two N-element vectors (row · col) using LANES multipliers per cycle. It supports signed or unsigned operands and optional accumulation onto the previous result. It is the general successor of the fixed 2-element multiply-add ALU, and sits between the matrix operand fetch logic and the result writeback path.

---
 rtl/dot_mac.sv | 94 +++++++++
 tb/tb_dot_mac.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/dot_mac.sv
// dot_mac: multi-cycle dot product of two N-element vectors, LANES products per cycle,
// signed or unsigned, optionally accumulated onto the previous result.
module dot_mac #(
    parameter int DW    = 8,
    parameter int N     = 4,
    parameter int LANES = 2,
    parameter int ACCW  = 2*DW+$clog2(N)+4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_mode,
    input  logic              acc_en,
    input  logic [N*DW-1:0]   row,
    input  logic [N*DW-1:0]   col,
    output logic              busy,
    output logic [ACCW-1:0]   out,
    output logic              complete
);
    localparam int CHUNKS = N / LANES;
    localparam int CW     = CHUNKS > 1 ? $clog2(CHUNKS) : 1;

    if (N < 1 || N % LANES != 0) begin : g_bad_n
        $error("dot_mac: N must be a positive multiple of LANES");
    end
    if (ACCW < 2*DW+$clog2(N)+1) begin : g_bad_accw
        $error("dot_mac: ACCW too narrow for an overflow-free dot product");
    end

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t            state;
    logic [N*DW-1:0]   row_q, col_q;
    logic              sm_q;
    logic [CW-1:0]     cnt;
    logic [ACCW-1:0]   acc, chunk_sum;
    logic [ACCW-1:0]   prod [LANES];

    // Operands shift down one chunk per MAC cycle, so the lanes always read the low elements.
    genvar l;
    for (l = 0; l < LANES; l++) begin : g_lane
        logic [2*DW-1:0] a, b, p;
        assign a = {{DW{sm_q & row_q[l*DW+DW-1]}}, row_q[l*DW +: DW]};
        assign b = {{DW{sm_q & col_q[l*DW+DW-1]}}, col_q[l*DW +: DW]};
        assign p = a * b;
        assign prod[l] = {{(ACCW-2*DW){sm_q & p[2*DW-1]}}, p};
    end

    always_comb begin
        chunk_sum = '0;
        for (int i = 0; i < LANES; i++) chunk_sum = chunk_sum + prod[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            sm_q     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            out      <= '0;
            busy     <= 1'b0;
            complete <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    row_q <= row;
                    col_q <= col;
                    sm_q  <= signed_mode;
                    acc   <= acc_en ? out : '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= MAC;
                end
                MAC: begin
                    acc   <= acc + chunk_sum;
                    row_q <= row_q >> (LANES*DW);
                    col_q <= col_q >> (LANES*DW);
                    cnt   <= cnt + CW'(1);
                    state <= cnt == CW'(CHUNKS-1) ? DONE : MAC;
                end
                DONE: begin
                    out      <= acc;
                    complete <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_mac.sv
// tb_dot_mac: directed vectors for dot_mac (DW=8, N=4, LANES=2, ACCW=22).
module tb_dot_mac;
    logic        clk, rst, start, signed_mode, acc_en, busy, complete;
    logic [31:0] row, col;
    logic [21:0] out;
    int          total = 0, bad = 0;

    dot_mac #(.DW(8), .N(4), .LANES(2), .ACCW(22)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .acc_en(acc_en),
        .row(row), .col(col), .busy(busy), .out(out), .complete(complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] r, c;
        logic        s, a;
        logic [21:0] e;
    } vec_t;

    function automatic logic [31:0] pk(input int e0, e1, e2, e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called at a negedge: presents one start, then counts edges until complete (bounded).
    task automatic run_op(input logic [31:0] r, c, input logic s, a, output int lat, output int nb);
        row = r; col = c; signed_mode = s; acc_en = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        nb = int'(busy);
        while (!complete && lat < 20) begin
            @(negedge clk);
            lat++;
            nb += int'(busy);
        end
    endtask

    vec_t        tv [9];
    logic [11:0] smp, aep;
    logic [21:0] bexp [3];
    int          lat, nb, cnt;

    initial begin
        tv[0] = '{pk(1,2,3,4),         pk(5,6,7,8),         1'b0, 1'b0, 22'd70};
        tv[1] = '{pk(255,255,255,255), pk(255,255,255,255), 1'b0, 1'b0, 22'd260100};
        tv[2] = '{pk(-128,-128,-128,-128), pk(-128,-128,-128,-128), 1'b1, 1'b0, 22'd65536};
        tv[3] = '{pk(-128,-128,-128,-128), pk(127,127,127,127), 1'b1, 1'b0, 22'h3F0200};
        tv[4] = '{pk(-1,2,-3,4),       pk(5,5,5,5),         1'b1, 1'b0, 22'd10};
        tv[5] = '{pk(1,1,1,1),         pk(1,1,1,1),         1'b1, 1'b1, 22'd14};
        tv[6] = '{pk(1,1,1,1),         pk(1,1,1,1),         1'b1, 1'b0, 22'd4};
        tv[7] = '{pk(255,255,255,255), pk(1,2,3,4),         1'b1, 1'b0, 22'h3FFFF6};
        tv[8] = '{pk(1,2,3,4),         pk(5,6,7,8),         1'b0, 1'b1, 22'd60};

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; acc_en = 1'b0; row = '0; col = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset complete", 32'(complete), 0);
        chk("reset out", 32'(out), 0);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d idle complete", i), 32'(complete), 0);
            run_op(tv[i].r, tv[i].c, tv[i].s, tv[i].a, lat, nb);
            chk($sformatf("vec%0d latency", i), 32'(lat), 3);
            chk($sformatf("vec%0d busy cycles", i), 32'(nb), 3);
            chk($sformatf("vec%0d out", i), 32'(out), 32'(tv[i].e));
        end
        @(negedge clk);
        chk("pulse width", 32'(complete), 0);

        // start held high with operands and modes changing every cycle
        smp = 12'b1110_1001_0110;
        aep = 12'b1001_0110_1110;
        bexp[0] = 22'd1920;
        bexp[1] = 22'd4194208;
        bexp[2] = 22'd1888;
        for (int k = 0; k < 12; k++) begin
            row = {4{8'(8'hF0 + k)}};
            col = {4{8'd2}};
            signed_mode = smp[k];
            acc_en = aep[k];
            start = 1'b1;
            @(negedge clk);
            chk($sformatf("busy win complete@%0d", k), 32'(complete), 32'(k % 4 == 3));
            if (k % 4 == 3) chk($sformatf("busy win out%0d", k / 4), 32'(out), 32'(bexp[k / 4]));
        end
        start = 1'b0;
        @(negedge clk);

        // back-to-back: second start issued in the complete cycle
        run_op(pk(1,2,3,4), pk(5,6,7,8), 1'b0, 1'b0, lat, nb);
        chk("b2b first out", 32'(out), 70);
        run_op(pk(1,1,1,1), pk(2,2,2,2), 1'b0, 1'b1, lat, nb);
        chk("b2b second latency", 32'(lat), 3);
        chk("b2b second out", 32'(out), 78);

        // reset during MAC
        @(negedge clk);
        row = pk(1,2,3,4); col = pk(5,6,7,8); signed_mode = 1'b0; acc_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid reset busy", 32'(busy), 0);
        chk("mid reset out", 32'(out), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(complete);
        end
        chk("mid reset no complete", 32'(cnt), 0);
        run_op(pk(1,2,3,4), pk(5,6,7,8), 1'b0, 1'b1, lat, nb);
        chk("post reset latency", 32'(lat), 3);
        chk("post reset out", 32'(out), 70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
